// File: rtl/bist_misr_compactor.sv
// Output-side BIST sequencer: walks INIT/SHIFT/CAPTURE for the scan wrapper,
// compacts the 7 scan-out chains into a 7-bit MISR and checks the final signature.
module bist_misr_compactor #(
  parameter int         CHAIN_LEN    = 33,
  parameter int         NUM_PATTERNS = 100,
  parameter logic [6:0] GOLDEN       = 7'h00,
  parameter int         CNT_W        = 16
) (
  input  logic             CK,
  input  logic             COMP_reset,
  input  logic             start,
  input  logic [6:0]       so_in,
  output logic             scan_en,
  output logic             bist_en,
  output logic             tpg_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [6:0]       signature,
  output logic [CNT_W-1:0] pattern_count,
  output logic [2:0]       state_dbg
);

  // Request protocol: start is a level request sampled only in IDLE or DONE;
  // there is no ready/ack, the run is acknowledged by busy rising the next cycle.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] PAT_MAX    = CNT_W'(NUM_PATTERNS);

  state_t           state;
  logic [CNT_W-1:0] shift_cnt;
  logic [6:0]       misr_nxt;
  logic             compact;

  // The first shift pass only loads the chains, so it is never compacted.
  assign compact   = (state == S_SHIFT) && (pattern_count != '0);
  assign misr_nxt  = {signature[5] ^ signature[6] ^ so_in[6],
                      signature[4:0] ^ so_in[5:1],
                      signature[6] ^ so_in[0]};
  assign state_dbg = state;

  always_ff @(posedge CK) begin
    if (COMP_reset) begin
      state         <= S_IDLE;
      shift_cnt     <= '0;
      scan_en       <= 1'b0;
      bist_en       <= 1'b0;
      tpg_reset     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      signature     <= '0;
      pattern_count <= '0;
    end else begin
      if (compact) signature <= misr_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_INIT;
            tpg_reset     <= 1'b1;
            bist_en       <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            scan_en       <= 1'b0;
            signature     <= '0;
            pattern_count <= '0;
            shift_cnt     <= '0;
          end
        end
        S_INIT: begin
          state     <= S_SHIFT;
          tpg_reset <= 1'b0;
          scan_en   <= 1'b1;
          signature <= '0;
          shift_cnt <= '0;
        end
        S_SHIFT: begin
          if (shift_cnt == LAST_SHIFT) begin
            shift_cnt <= '0;
            scan_en   <= 1'b0;
            if (pattern_count < PAT_MAX) begin
              state <= S_CAPTURE;
            end else begin
              state   <= S_DONE;
              bist_en <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              // Compare the signature as it will be held in DONE, including this cycle's update.
              pass    <= ((compact ? misr_nxt : signature) == GOLDEN);
            end
          end else begin
            shift_cnt <= shift_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          state   <= S_SHIFT;
          scan_en <= 1'b1;
          if (pattern_count < PAT_MAX) pattern_count <= pattern_count + CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Bench for bist_misr_compactor (CHAIN_LEN=4, NUM_PATTERNS=2): directed and random runs
// checked cycle by cycle against a phase/arithmetic reference of the BIST schedule.
module tb_bist_misr_compactor;

  localparam int CL       = 4;
  localparam int NP       = 2;
  localparam int CW       = 16;
  localparam int RUN_LAST = 1 + CL * (NP + 1) + NP;

  logic          CK = 1'b0;
  logic          COMP_reset;
  logic          start;
  logic [6:0]    so_in;

  logic          scan_en_a, bist_en_a, tpg_reset_a, busy_a, done_a, pass_a;
  logic [6:0]    sig_a;
  logic [CW-1:0] pc_a;
  logic [2:0]    dbg_a;
  logic          scan_en_g, bist_en_g, tpg_reset_g, busy_g, done_g, pass_g;
  logic [6:0]    sig_g;
  logic [CW-1:0] pc_g;
  logic [2:0]    dbg_g;
  logic [4:0]    ctrl_a, ctrl_g;

  int            total = 0;
  int            bad   = 0;
  logic [6:0]    stim [0:31];

  assign ctrl_a = {tpg_reset_a, scan_en_a, bist_en_a, busy_a, done_a};
  assign ctrl_g = {tpg_reset_g, scan_en_g, bist_en_g, busy_g, done_g};

  bist_misr_compactor #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .GOLDEN(7'h00), .CNT_W(CW)) dut (
    .CK(CK), .COMP_reset(COMP_reset), .start(start), .so_in(so_in),
    .scan_en(scan_en_a), .bist_en(bist_en_a), .tpg_reset(tpg_reset_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a), .pattern_count(pc_a), .state_dbg(dbg_a)
  );

  bist_misr_compactor #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .GOLDEN(7'h41), .CNT_W(CW)) dut_g (
    .CK(CK), .COMP_reset(COMP_reset), .start(start), .so_in(so_in),
    .scan_en(scan_en_g), .bist_en(bist_en_g), .tpg_reset(tpg_reset_g), .busy(busy_g),
    .done(done_g), .pass(pass_g), .signature(sig_g), .pattern_count(pc_g), .state_dbg(dbg_g)
  );

  // clock / reset block
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl_a"}, 32'(ctrl_a), 32'd0);
    check({tag, "_ctrl_g"}, 32'(ctrl_g), 32'd0);
    check({tag, "_pass_a"}, 32'(pass_a), 32'd0);
    check({tag, "_pass_g"}, 32'(pass_g), 32'd0);
    check({tag, "_sig"},    32'(sig_a),  32'd0);
    check({tag, "_pc"},     32'(pc_a),   32'd0);
  endtask

  // Polynomial x^7+x^6+1 as a shift-left with conditional feedback, then inject the chain bits.
  function automatic logic [6:0] misr_step(input logic [6:0] q, input logic [6:0] d);
    logic [7:0] t;
    t = {q, 1'b0} ^ (q[6] ? 8'h41 : 8'h00);
    return t[6:0] ^ d;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < 32; i++) stim[i] = 7'h00;
  endtask

  task automatic random_stim();
    for (int i = 0; i < 32; i++) stim[i] = 7'($urandom_range(0, 127));
  endtask

  // One run: start sampled, then cycle c (1 = INIT) driven with stim[c] and checked.
  task automatic do_run(input int restart_at, input int reset_at);
    logic [6:0] q;
    int         pc;
    int         ph;
    int         k;
    logic [4:0] exp_ctrl;
    q  = 7'h00;
    pc = 0;
    start = 1'b1;
    so_in = 7'($urandom_range(0, 127));
    @(posedge CK); #1;
    for (int c = 1; c <= RUN_LAST + 3; c++) begin
      if (reset_at != 0 && c == reset_at + 1) begin
        COMP_reset = 1'b0;
        check_idle($sformatf("rst_c%0d", c));
        break;
      end
      so_in      = stim[c];
      start      = (c == restart_at);
      COMP_reset = (c == reset_at);
      k = c - 2;
      if (c == 1)             ph = 0;
      else if (c > RUN_LAST)  ph = 3;
      else if ((k % (CL + 1)) < CL) ph = 1;
      else                    ph = 2;
      exp_ctrl = {ph == 0, ph == 1, ph != 3, ph != 3, ph == 3};
      check($sformatf("c%0d_ctrl_a", c), 32'(ctrl_a), 32'(exp_ctrl));
      check($sformatf("c%0d_ctrl_g", c), 32'(ctrl_g), 32'(exp_ctrl));
      check($sformatf("c%0d_sig_a", c),  32'(sig_a),  32'(q));
      check($sformatf("c%0d_sig_g", c),  32'(sig_g),  32'(q));
      check($sformatf("c%0d_pc_a", c),   32'(pc_a),   32'(pc));
      check($sformatf("c%0d_pc_g", c),   32'(pc_g),   32'(pc));
      check($sformatf("c%0d_state_agree", c), 32'(dbg_a), 32'(dbg_g));
      if (ph == 3) begin
        check($sformatf("c%0d_pass_a", c), 32'(pass_a), 32'(q == 7'h00));
        check($sformatf("c%0d_pass_g", c), 32'(pass_g), 32'(q == 7'h41));
      end
      if (ph == 1 && (k / (CL + 1)) > 0) q = misr_step(q, stim[c]);
      if (ph == 2) pc++;
      @(posedge CK); #1;
    end
    start      = 1'b0;
    COMP_reset = 1'b0;
    so_in      = 7'h00;
  endtask

  initial begin
    COMP_reset = 1'b1;
    start      = 1'b0;
    so_in      = 7'h00;
    repeat (3) @(posedge CK);
    #1;
    check_idle("reset");
    COMP_reset = 1'b0;
    repeat (3) begin
      so_in = 7'($urandom_range(0, 127));
      @(posedge CK); #1;
      check_idle("idle");
    end

    // all-zero chains: signature 0, then restart from DONE and expect the same result
    clear_stim();
    do_run(0, 0);
    check("zero_sig", 32'(sig_a), 32'h00);
    check("zero_pass", 32'(pass_a), 32'd1);
    do_run(0, 0);
    check("zero_again_sig", 32'(sig_a), 32'h00);

    // single bit in the first compacted cycle
    clear_stim();
    stim[7] = 7'h01;
    do_run(0, 0);
    check("bit7_sig", 32'(sig_a), 32'h41);
    check("bit7_pass_g41", 32'(pass_g), 32'd1);
    check("bit7_pass_g00", 32'(pass_a), 32'd0);

    // activity only in non-compacting cycles
    clear_stim();
    for (int i = 1; i <= 6; i++) stim[i] = 7'h7F;
    stim[11] = 7'h7F;
    do_run(0, 0);
    check("noncompact_sig", 32'(sig_a), 32'h00);

    // start while busy is ignored
    random_stim();
    do_run(8, 0);

    // reset mid-run, then a fresh full run
    random_stim();
    do_run(0, 9);
    random_stim();
    do_run(0, 0);

    repeat (4) begin
      random_stim();
      do_run(0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
